// File: rtl/regex_imem_responder_if.sv
// Fetch/host bus bundle for regex_imem_responder.
// master: the CPU fetch initiators and the host loader; slave: the responder.
interface regex_imem_responder_if #(
  parameter int unsigned N_PORTS           = 2,
  parameter int unsigned MEMORY_WIDTH      = 16,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11
);
  logic [N_PORTS-1:0]                   cpu_valid;
  logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] cpu_addr;
  logic [N_PORTS-1:0]                   cpu_ready;
  logic [MEMORY_WIDTH-1:0]              cpu_data;
  logic                                 wr_valid;
  logic [MEMORY_ADDR_WIDTH-1:0]         wr_addr;
  logic [MEMORY_WIDTH-1:0]              wr_data;
  logic                                 wr_ready;

  modport master (
    output cpu_valid, cpu_addr, wr_valid, wr_addr, wr_data,
    input  cpu_ready, cpu_data, wr_ready
  );

  modport slave (
    input  cpu_valid, cpu_addr, wr_valid, wr_addr, wr_data,
    output cpu_ready, cpu_data, wr_ready
  );
endinterface

// File: rtl/regex_imem_responder.sv
// Instruction-memory responder: N_PORTS round-robin fetch ports plus a host
// write port sharing one single-port RAM. The RAM is filled with CLEAR_WORD
// after every reset; init_done rises once the fill completes.
// Optional macro REGEX_IMEM_STATS_EN adds saturating fetch/stall counters.
module regex_imem_responder #(
  parameter int unsigned             N_PORTS           = 2,
  parameter int unsigned             MEMORY_WIDTH      = 16,
  parameter int unsigned             MEMORY_ADDR_WIDTH = 11,
  parameter logic [MEMORY_WIDTH-1:0] CLEAR_WORD        = 16'h8000
) (
  input  logic                  clk,
  input  logic                  rst,
  regex_imem_responder_if.slave bus,
  output logic                  init_done
`ifdef REGEX_IMEM_STATS_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);
  localparam int unsigned AW    = MEMORY_ADDR_WIDTH;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]              state;
  logic [AW-1:0]           clr_addr;
  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           rr_next;
  logic [MEMORY_WIDTH-1:0] mem [DEPTH];
  logic [MEMORY_WIDTH-1:0] rd_data;
  logic [N_PORTS-1:0]      grant;
  logic [N_PORTS-1:0]      ready;
  logic [AW-1:0]           rd_addr;
  logic                    found;
  logic                    rd_en;

  // Round-robin search: ports at or above rr_ptr first, then the wrapped ones.
  always_comb begin
    found   = 1'b0;
    grant   = '0;
    rd_addr = '0;
    rr_next = rr_ptr;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (!found && bus.cpu_valid[i] &&
            ((pass == 0) == (i >= 32'(rr_ptr)))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          rd_addr  = bus.cpu_addr[i*AW +: AW];
          rr_next  = (i == N_PORTS - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

  assign rd_en         = (state == S_RUN) && !bus.wr_valid && found;
  assign ready         = rd_en ? grant : '0;
  assign bus.cpu_ready = ready;
  assign bus.wr_ready  = (state == S_RUN) && bus.wr_valid;
  assign bus.cpu_data  = rd_data;
  assign init_done     = (state == S_RUN);

  // Control state: clear sweep, then run with the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
      rr_ptr   <= '0;
    end else if (state == S_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == '1) state <= S_RUN;
    end else if (rd_en) begin
      rr_ptr <= rr_next;
    end
  end

  // RAM write port: clear fill during S_CLEAR, host writes afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) mem[clr_addr] <= CLEAR_WORD;
      else if (bus.wr_valid) mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Registered read data, updated only by a read grant.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

`ifdef REGEX_IMEM_STATS_EN
  logic [32:0] fetch_sum;
  logic [32:0] stall_sum;

  always_comb begin
    fetch_sum = {1'b0, fetch_count} + 33'(rd_en);
    stall_sum = {1'b0, stall_count} + 33'($countones(bus.cpu_valid & ~ready));
  end

  // Saturating statistics, counting only while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else if (state == S_RUN) begin
      fetch_count <= fetch_sum[32] ? '1 : fetch_sum[31:0];
      stall_count <= stall_sum[32] ? '1 : stall_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_regex_imem_responder.sv
// Bench for regex_imem_responder with AW=4, two fetch ports.
module tb_regex_imem_responder;
  localparam int NP    = 2;
  localparam int W     = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic init_done;
`ifdef REGEX_IMEM_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  regex_imem_responder_if #(.N_PORTS(NP), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)) bus ();

  regex_imem_responder #(
    .N_PORTS(NP), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .CLEAR_WORD(16'h8000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .init_done(init_done)
`ifdef REGEX_IMEM_STATS_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, "next favoured port", last fetched word.
  bit          known = 1'b0;
  bit          m_run;
  int          m_clr;
  int          m_ptr;
  logic [15:0] m_data;
  logic [15:0] m_mem [DEPTH];
  longint      m_fetch;
  longint      m_stall;

  always @(negedge clk) begin
    logic [1:0]  e_rdy;
    logic        e_wr;
    logic [7:0]  addrs;
    int          g;
    int          p;
    int          nv;
    e_rdy = '0;
    e_wr  = 1'b0;
    g     = -1;
    if (known && m_run) begin
      if (bus.wr_valid) e_wr = 1'b1;
      else begin
        for (int k = 0; k < NP; k++) begin
          p = (m_ptr + k) % NP;
          if (g < 0 && ((bus.cpu_valid >> p) & 2'b01) != 2'b00) g = p;
        end
      end
      if (g >= 0) e_rdy = 2'(1 << g);
    end
    if (known) begin
      chk("cpu_ready", 32'(bus.cpu_ready), 32'(e_rdy));
      chk("wr_ready",  32'(bus.wr_ready),  32'(e_wr));
      chk("init_done", 32'(init_done),     32'(m_run));
      chk("cpu_data",  32'(bus.cpu_data),  32'(m_data));
`ifdef REGEX_IMEM_STATS_EN
      chk("fetch_count", fetch_count, 32'(m_fetch));
      chk("stall_count", stall_count, 32'(m_stall));
`endif
    end
    if (rst) begin
      known   = 1'b1;
      m_run   = 1'b0;
      m_clr   = 0;
      m_ptr   = 0;
      m_data  = '0;
      m_fetch = 0;
      m_stall = 0;
    end else if (known && !m_run) begin
      m_clr++;
      if (m_clr == DEPTH) begin
        m_run = 1'b1;
        foreach (m_mem[i]) m_mem[i] = 16'h8000;
      end
    end else if (known) begin
      nv = $countones(bus.cpu_valid);
      if (e_wr) m_mem[bus.wr_addr] = bus.wr_data;
      else if (g >= 0) begin
        addrs   = bus.cpu_addr >> (g * AW);
        m_data  = m_mem[addrs[3:0]];
        m_ptr   = (g + 1) % NP;
        m_fetch = m_fetch + 1;
        nv--;
      end
      m_stall = m_stall + nv;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (init_done) break;
      n++;
    end
    chk(name, 32'(n), 32'd16);
    nxt();
  endtask

  logic [1:0] exp3 [4];

  initial begin
    rst           = 1'b1;
    bus.cpu_valid = '0;
    bus.cpu_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    exp3 = '{2'b01, 2'b10, 2'b01, 2'b10};
    nxt();
    nxt();
    rst = 1'b0;

    // 1: clear takes 16 cycles, then every word reads back as 8000
    wait_init("init_cycles");
    for (int a = 0; a < DEPTH; a++) begin
      bus.cpu_valid = 2'b01;
      bus.cpu_addr  = {4'd0, 4'(a)};
      nxt();
      chk("clear_word", 32'(bus.cpu_data), 32'h8000);
    end
    bus.cpu_valid = '0;
    nxt();

    // 2: write 5A1F @3, then port0 reads @3 next cycle
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd3;
    bus.wr_data  = 16'h5A1F;
    @(negedge clk);
    chk("t2_wr_ready", 32'(bus.wr_ready), 32'd1);
    nxt();
    bus.wr_valid  = 1'b0;
    bus.cpu_valid = 2'b01;
    bus.cpu_addr  = {4'd0, 4'd3};
    @(negedge clk);
    chk("t2_ready", 32'(bus.cpu_ready), 32'h1);
    nxt();
    bus.cpu_valid = '0;
    chk("t2_data", 32'(bus.cpu_data), 32'h5A1F);

    // 3: one port1 fetch moves the pointer back to 0, then both request
    bus.cpu_valid = 2'b10;
    bus.cpu_addr  = '0;
    nxt();
    bus.cpu_valid = 2'b11;
    bus.cpu_addr  = {4'd5, 4'd3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_alternate", 32'(bus.cpu_ready), 32'(exp3[i]));
      nxt();
    end
    bus.cpu_valid = '0;

    // 4: write and port1 request collide; write wins, port1 follows
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 4'd5;
    bus.wr_data   = 16'h1234;
    bus.cpu_valid = 2'b10;
    bus.cpu_addr  = {4'd5, 4'd0};
    @(negedge clk);
    chk("t4_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("t4_no_grant", 32'(bus.cpu_ready), 32'h0);
    nxt();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("t4_port1", 32'(bus.cpu_ready), 32'h2);
    nxt();
    bus.cpu_valid = '0;
    chk("t4_raw_data", 32'(bus.cpu_data), 32'h1234);

    // 5: reset, then reset again once clr_addr reaches 7
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    repeat (7) nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chk("t5_data_reset", 32'(bus.cpu_data), 32'h0);
    wait_init("t5_init_cycles");

    // 6: five grants and three stalled port-cycles
    bus.cpu_addr  = {4'd2, 4'd1};
    bus.cpu_valid = 2'b11; nxt();
    bus.cpu_valid = 2'b11; nxt();
    bus.cpu_valid = 2'b11; nxt();
    bus.cpu_valid = 2'b01; nxt();
    bus.cpu_valid = 2'b10; nxt();
    bus.cpu_valid = '0;
    chk("t6_last_data", 32'(bus.cpu_data), 32'h8000);
`ifdef REGEX_IMEM_STATS_EN
    chk("t6_fetch_count", fetch_count, 32'd5);
    chk("t6_stall_count", stall_count, 32'd3);
`endif

    // earlier program contents are gone after the re-clear
    bus.cpu_valid = 2'b01;
    bus.cpu_addr  = {4'd0, 4'd3};
    nxt();
    bus.cpu_valid = '0;
    chk("t5_recleared", 32'(bus.cpu_data), 32'h8000);
    nxt();
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
